// File: rtl/ldpc_bf_pkg.sv
// ldpc_bf_pkg: shared types and width helpers for the bit-flipping LDPC
// decoder controller.
//   state_t     - scheduler FSM states
//   w_min1()    - clog2 clamped to at least one bit
//   row_w()     - width of a row index for M parity-check rows
//   iter_w()    - width of an iteration count reaching MAX_ITER
//   fail_w()    - width of an unsatisfied-row count reaching M
package ldpc_bf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CHECK_REQ,
    CHECK_WAIT,
    DECIDE,
    FLIP,
    FLIP_WAIT,
    DONE
  } state_t;

  function automatic int unsigned w_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned row_w(input int unsigned m_checks);
    return w_min1(m_checks);
  endfunction

  function automatic int unsigned iter_w(input int unsigned max_iter);
    return w_min1(max_iter + 1);
  endfunction

  function automatic int unsigned fail_w(input int unsigned m_checks);
    return w_min1(m_checks + 1);
  endfunction

endpackage

// File: rtl/ldpc_bf_wdog.sv
// ldpc_bf_wdog: cycle watchdog for the controller's datapath waits.
//   clk, rst  - clock, asynchronous active-low reset
//   clear     - restart the count (held while not waiting)
//   enable    - count this cycle
//   expired   - high in the LIMIT-th consecutive enabled cycle
module ldpc_bf_wdog
  import ldpc_bf_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = w_min1(LIMIT);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ldpc_bf_ctrl.sv
// ldpc_bf_ctrl: iteration scheduler for the bit-flipping LDPC decoder.
// Each pass clears the datapath counters, evaluates every parity-check row,
// then finishes (zero syndrome or MAX_ITER flips) or commands one bit flip.
// Optional watchdog: define LDPC_BF_CTRL_TIMEOUT_EN to abort a datapath wait
// after TIMEOUT cycles (err=1); otherwise waits are unbounded and err=0.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   start               - decode request (sampled in IDLE)
//   busy, done          - decode in progress / one-cycle end pulse
//   success, err        - verdict and watchdog-abort flag, held until next start
//   iter_cnt, fail_cnt  - flips performed / unsatisfied rows of latest pass
//   syn_clr             - clear datapath unsatisfied-check counters
//   chk_addr, chk_en    - row evaluation request
//   chk_valid, chk_fail - row evaluation result
//   flip_en, flip_ack   - bit-flip command and write-back acknowledge
module ldpc_bf_ctrl
  import ldpc_bf_pkg::*;
#(
  parameter int unsigned M_CHECKS = 4,
  parameter int unsigned MAX_ITER = 10,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          success,
  output logic                          err,
  output logic [iter_w(MAX_ITER)-1:0]   iter_cnt,
  output logic [fail_w(M_CHECKS)-1:0]   fail_cnt,
  output logic                          syn_clr,
  output logic [row_w(M_CHECKS)-1:0]    chk_addr,
  output logic                          chk_en,
  input  logic                          chk_valid,
  input  logic                          chk_fail,
  output logic                          flip_en,
  input  logic                          flip_ack
);

  localparam int unsigned RW = row_w(M_CHECKS);
  localparam int unsigned IW = iter_w(MAX_ITER);
  localparam int unsigned FW = fail_w(M_CHECKS);

  state_t        state, state_next;
  logic [RW-1:0] row;
  logic [FW-1:0] acc, acc_next;
  logic          last_row;
  logic          wd_expired;

  assign chk_addr = row;
  assign last_row = (row == RW'(M_CHECKS - 1));
  assign acc_next = (chk_fail && (acc != FW'(M_CHECKS))) ? acc + FW'(1) : acc;

`ifdef LDPC_BF_CTRL_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state == CHECK_WAIT) || (state == FLIP_WAIT);

  // Clearing whenever outside a wait state restarts the count on every entry.
  ldpc_bf_wdog #(.LIMIT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (wd_expired &&
                 ((state == CHECK_WAIT && !chk_valid) ||
                  (state == FLIP_WAIT  && !flip_ack))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expired     = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    syn_clr    = 1'b0;
    chk_en     = 1'b0;
    flip_en    = 1'b0;
    unique case (state)
      IDLE:       if (start) state_next = CLEAR;
      CLEAR: begin
        syn_clr    = 1'b1;
        state_next = CHECK_REQ;
      end
      CHECK_REQ: begin
        chk_en     = 1'b1;
        state_next = CHECK_WAIT;
      end
      // A response in the expiry cycle takes priority over the watchdog.
      CHECK_WAIT: begin
        if (chk_valid)       state_next = last_row ? DECIDE : CHECK_REQ;
        else if (wd_expired) state_next = DONE;
      end
      DECIDE: begin
        if (fail_cnt == '0)                 state_next = DONE;
        else if (iter_cnt == IW'(MAX_ITER)) state_next = DONE;
        else                                state_next = FLIP;
      end
      FLIP: begin
        flip_en    = 1'b1;
        state_next = FLIP_WAIT;
      end
      FLIP_WAIT: begin
        if (flip_ack)        state_next = CLEAR;
        else if (wd_expired) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row      <= '0;
      acc      <= '0;
      fail_cnt <= '0;
      iter_cnt <= '0;
      success  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            iter_cnt <= '0;
            success  <= 1'b0;
          end
        end
        CLEAR: begin
          row <= '0;
          acc <= '0;
        end
        CHECK_WAIT: begin
          if (chk_valid) begin
            acc <= acc_next;
            if (last_row) fail_cnt <= acc_next;
            else          row      <= row + RW'(1);
          end
        end
        DECIDE: begin
          if (fail_cnt == '0) success <= 1'b1;
        end
        FLIP_WAIT: begin
          if (flip_ack && (iter_cnt != IW'(MAX_ITER))) iter_cnt <= iter_cnt + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_bf_ctrl.sv
// tb_ldpc_bf_ctrl: directed self-checking bench for ldpc_bf_ctrl
// (M_CHECKS=4, MAX_ITER=10, TIMEOUT=64). A small datapath responder answers
// chk_en/flip_en one cycle later using per-pass row failure masks.
module tb_ldpc_bf_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, success, err;
  logic [3:0] iter_cnt;
  logic [2:0] fail_cnt;
  logic       syn_clr, chk_en, flip_en;
  logic [1:0] chk_addr;
  logic       chk_valid, chk_fail, flip_ack;

  always #5 clk = ~clk;

  ldpc_bf_ctrl #(.M_CHECKS(4), .MAX_ITER(10), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .success   (success),
    .err       (err),
    .iter_cnt  (iter_cnt),
    .fail_cnt  (fail_cnt),
    .syn_clr   (syn_clr),
    .chk_addr  (chk_addr),
    .chk_en    (chk_en),
    .chk_valid (chk_valid),
    .chk_fail  (chk_fail),
    .flip_en   (flip_en),
    .flip_ack  (flip_ack)
  );

  int   cyc = 0;
  int   n_syn = 0, n_chk = 0, n_flip = 0, n_done = 0;
  int   base_syn = 0;
  logic resp_on = 1'b0;
  logic [3:0] mask_first = '0, mask_rest = '0;
  logic pend_chk = 1'b0, pend_fail = 1'b0, pend_flip = 1'b0;
  logic resp_valid = 1'b0, resp_fail = 1'b0, resp_ack = 1'b0;
  logic glitch_valid = 1'b0, glitch_ack = 1'b0;

  assign chk_valid = resp_valid | glitch_valid;
  assign chk_fail  = resp_fail;
  assign flip_ack  = resp_ack | glitch_ack;

  // Datapath model: responses appear in the cycle after the request.
  always @(posedge clk) begin
    cyc++;
    #1;
    resp_valid = pend_chk;
    resp_fail  = pend_fail;
    resp_ack   = pend_flip;
    if (syn_clr) n_syn++;
    if (chk_en)  n_chk++;
    if (flip_en) n_flip++;
    if (done)    n_done++;
    pend_chk  = resp_on && chk_en;
    pend_fail = ((n_syn - base_syn) <= 1) ? mask_first[chk_addr] : mask_rest[chk_addr];
    pend_flip = resp_on && flip_en;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_decode(output int t0);
    start = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  int t0, at, b_chk, b_flip, b_done;
  bit ok, busy_all;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_success", success, 0);
    chk("rst_err", err, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_pulses", {syn_clr, chk_en, flip_en}, 0);
    chk("rst_addr", chk_addr, 0);
    rst = 1'b1;
    tick();

    // Clean word
    resp_on = 1'b1; mask_first = 4'b0000; mask_rest = 4'b0000;
    base_syn = n_syn; b_chk = n_chk;
    start_decode(t0);
    wait_done(50, at, ok);
    chk("clean_done_seen", ok, 1);
    chk("clean_done_cycle", at - t0, 11);
    chk("clean_busy_in_done", busy, 1);
    chk("clean_success", success, 1);
    chk("clean_iter", iter_cnt, 0);
    chk("clean_fail", fail_cnt, 0);
    chk("clean_chk_en", n_chk - b_chk, 4);
    tick();
    chk("clean_busy_after", busy, 0);
    chk("clean_success_held", success, 1);

    // Rows 1 and 3 fail in pass 1, one flip fixes it
    mask_first = 4'b1010; mask_rest = 4'b0000;
    base_syn = n_syn; b_flip = n_flip;
    start_decode(t0);
    wait_done(100, at, ok);
    chk("flip1_done_seen", ok, 1);
    chk("flip1_done_cycle", at - t0, 23);
    chk("flip1_flips", n_flip - b_flip, 1);
    chk("flip1_iter", iter_cnt, 1);
    chk("flip1_success", success, 1);
    chk("flip1_fail", fail_cnt, 0);
    tick();

    // Row 0 always fails: exhaust MAX_ITER
    mask_first = 4'b0001; mask_rest = 4'b0001;
    base_syn = n_syn; b_flip = n_flip;
    start_decode(t0);
    wait_done(400, at, ok);
    chk("maxit_done_seen", ok, 1);
    chk("maxit_done_cycle", at - t0, 131);
    chk("maxit_flips", n_flip - b_flip, 10);
    chk("maxit_syn_clr", n_syn - base_syn, 11);
    chk("maxit_success", success, 0);
    chk("maxit_iter", iter_cnt, 10);
    chk("maxit_fail", fail_cnt, 1);
    tick(); tick();
    chk("maxit_iter_held", iter_cnt, 10);
    chk("maxit_fail_held", fail_cnt, 1);

    // start pulsed in CHECK_WAIT is ignored
    mask_first = 4'b0000; mask_rest = 4'b0000;
    base_syn = n_syn; b_chk = n_chk;
    start_decode(t0);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50, at, ok);
    chk("ign_start_done_cycle", at - t0, 11);
    chk("ign_start_chk_en", n_chk - b_chk, 4);
    tick();

    // chk_valid / flip_ack glitches in IDLE are ignored
    b_chk = n_chk; b_flip = n_flip; b_done = n_done;
    busy_all = 1'b0;
    glitch_valid = 1'b1; glitch_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) busy_all = 1'b1;
    end
    glitch_valid = 1'b0; glitch_ack = 1'b0;
    tick();
    chk("glitch_busy", busy_all, 0);
    chk("glitch_pulses", (n_chk - b_chk) + (n_flip - b_flip) + (n_done - b_done), 0);

    // Reset during FLIP_WAIT with iter_cnt = 3
    mask_first = 4'b0001; mask_rest = 4'b0001;
    base_syn = n_syn; b_flip = n_flip; b_done = n_done;
    start_decode(t0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_flip - b_flip == 4) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("rstmid_reach_flip4", ok, 1);
    tick();
    chk("rstmid_iter_before", iter_cnt, 3);
    rst = 1'b0;
    #1;
    chk("rstmid_outputs", {busy, done, success, err, iter_cnt, fail_cnt,
                           syn_clr, chk_addr, chk_en, flip_en}, 0);
    tick(); tick();
    chk("rstmid_outputs_held", {busy, done, iter_cnt, fail_cnt, flip_en}, 0);
    chk("rstmid_no_done", n_done - b_done, 0);
    rst = 1'b1;
    mask_first = 4'b0000; mask_rest = 4'b0000;
    tick();
    base_syn = n_syn;
    start_decode(t0);
    wait_done(50, at, ok);
    chk("rstmid_rerun_done_cycle", at - t0, 11);
    chk("rstmid_rerun_success", success, 1);
    tick();

    // Datapath never answers
    resp_on = 1'b0;
    start_decode(t0);
`ifdef LDPC_BF_CTRL_TIMEOUT_EN
    wait_done(200, at, ok);
    chk("wdog_done_seen", ok, 1);
    chk("wdog_done_cycle", at - t0, 67);
    chk("wdog_err", err, 1);
    chk("wdog_success", success, 0);
    tick();
`else
    busy_all = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy) busy_all = 1'b0;
    end
    chk("nowdog_busy_held", busy_all, 1);
    chk("nowdog_err", err, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldpc_bf_ctrl.md
# ldpc_bf_ctrl

Iteration scheduler for the bit-flipping LDPC decoder datapath. On `start` it sequences the datapath through repeated passes: clear counters, evaluate every parity-check row, then either finish or command one bit flip. It stops on a zero syndrome (success) or after `MAX_ITER` flips (failure). It sits between the top-level decode request and the codeword memory/parity datapath, and owns the iteration count and the decode verdict.

## Interface
- `M_CHECKS`, 4, number of parity-check rows (≥2)
- `MAX_ITER`, 10, maximum flip iterations before declaring failure (≥1)
- `TIMEOUT`, 64, watchdog limit in cycles per datapath wait (used only with the macro)
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: decode request, sampled in IDLE only
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle
- `done` out 1: one-cycle pulse ending a decode
- `success` out 1: verdict, valid with `done`, held until next accepted `start`
- `err` out 1: watchdog abort flag, valid with `done`, held like `success`
- `iter_cnt` out clog2(MAX_ITER+1): flips performed in current/last decode
- `fail_cnt` out clog2(M_CHECKS+1): unsatisfied rows in latest complete pass
- `syn_clr` out 1: one-cycle pulse clearing datapath unsatisfied-check counters
- `chk_addr` out clog2(M_CHECKS): row index under evaluation
- `chk_en` out 1: one-cycle request to evaluate row `chk_addr`
- `chk_valid` in 1: datapath result strobe
- `chk_fail` in 1: row parity unsatisfied, qualified by `chk_valid`
- `flip_en` out 1: one-cycle command to flip the bit with the highest unsatisfied count
- `flip_ack` in 1: flip written back to codeword memory

## Operation
- All outputs reset to 0; state resets to IDLE.
- The FSM has these states:
  - **IDLE**: when `start` = 1, clear `iter_cnt`, `success` and `err`, then go to CLEAR.
  - **CLEAR**: assert `syn_clr`, set row = 0, set the accumulator to 0, then go to CHECK_REQ.
  - **CHECK_REQ**: assert `chk_en` with `chk_addr` = row, then go to CHECK_WAIT.
  - **CHECK_WAIT**: hold `chk_addr`. On `chk_valid`, add `chk_fail` to the accumulator.
    - If row = M_CHECKS−1, load `fail_cnt` from the accumulator (including the current `chk_fail`) and go to DECIDE.
    - Otherwise increment row and go to CHECK_REQ.
  - **DECIDE**: choose the next step in this priority order:
    - If `fail_cnt` = 0, set `success` = 1 and go to DONE.
    - Else if `iter_cnt` = MAX_ITER, go to DONE with `success` = 0.
    - Else go to FLIP.
  - **FLIP**: assert `flip_en`, then go to FLIP_WAIT.
  - **FLIP_WAIT**: on `flip_ack`, increment `iter_cnt` and go to CLEAR.
  - **DONE**: assert `done`, then go to IDLE.
- `start` outside IDLE is ignored.
- `chk_valid` outside CHECK_WAIT is ignored, as is `flip_ack` outside FLIP_WAIT.
- `chk_valid` and `flip_ack` may arrive in the cycle after the request at the earliest. Same-cycle responses are not supported.
- `iter_cnt` never exceeds MAX_ITER.
- The accumulator saturates at M_CHECKS.
- `rst` asserted mid-decode returns the block to IDLE immediately with all outputs 0. No `done` pulse is produced.

## Timing
- Take the cycle in which `start` is sampled as cycle 0. A clean word with a 1-cycle datapath gives:
  - CLEAR in cycle 1.
  - `chk_en` for row r in cycle 2+2r.
  - DECIDE in cycle 2M_CHECKS+2.
  - `done` in cycle 2M_CHECKS+3.
- Each flip iteration adds 2M_CHECKS+4 cycles with a 1-cycle `flip_ack`.
- `success`, `err` and `fail_cnt` are registered. They are stable from the `done` cycle until the next accepted `start`.
- `busy` falls in the cycle after `done`. A `start` held high across that boundary is accepted in that cycle.

## Configuration
- `LDPC_BF_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in CHECK_WAIT or FLIP_WAIT, resetting on each state entry.
  - On reaching TIMEOUT, the FSM goes to DONE with `err` = 1 and `success` = 0.
  - A response arriving in the same cycle as the timeout wins.
- Macro undefined: the waits are unbounded, and `err` is tied to 0.

## Structure
- Shared package `ldpc_bf_pkg` holds:
  - the FSM state enum (IDLE, CLEAR, CHECK_REQ, CHECK_WAIT, DECIDE, FLIP, FLIP_WAIT, DONE);
  - width helper constants for row, iteration and fail-count widths.
- One sub-module, `ldpc_bf_wdog`, provides the watchdog counter with `clear`/`enable` inputs and an `expired` output. It is instantiated only under the macro.

## Test plan
- M_CHECKS=4, datapath answers `chk_fail`=0 one cycle after each `chk_en` → `done` in cycle 11, `success`=1, `iter_cnt`=0, `fail_cnt`=0.
- Rows 1 and 3 fail in pass 1, all pass in pass 2, `flip_ack` 1 cycle after `flip_en` → exactly one `flip_en`, `iter_cnt`=1, `success`=1, `done` in cycle 23.
- Row 0 always fails, MAX_ITER=10 → ten `flip_en` pulses, eleven `syn_clr` pulses, then `done` with `success`=0, `iter_cnt`=10, `fail_cnt`=1.
- `start` pulsed in CHECK_WAIT, and `chk_valid`/`flip_ack` glitched in IDLE → no state change, no extra `chk_en`/`flip_en`.
- `rst` low during FLIP_WAIT with `iter_cnt`=3 → next cycle all outputs 0, no `done`; a fresh `start` runs normally.
- Macro on, TIMEOUT=64, `chk_valid` withheld → `done` with `err`=1, `success`=0 after 64 wait cycles. Macro off, same stimulus → `busy` stays 1 indefinitely and `err`=0.
